control_unit: RTL

Sequencing FSM for the rudimentary machine's datapath. It fetches each 16-bit instruction, decodes the opcode and condition/function fields, and drives the load strobes, mux selects and memory handshake that move data through the register file, the ALU and the immediate sign extender. It also resolves branches against the Z/N flags and traps into a sticky error state on illegal ALU encodings or a memory timeout.

---
 rtl/control_unit_if.sv | 35 +++
 rtl/control_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/control_unit_if.sv
// Control bundle between the sequencing FSM and the datapath.
// The master side is the control unit; the slave side is the datapath/memory.
interface control_unit_if;
  logic [1:0] ir_op;
  logic [2:0] ir_cond;
  logic [2:0] ir_func;
  logic       flag_z;
  logic       flag_n;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       addr_sel;
  logic       ld_ir;
  logic       ld_pc;
  logic       pc_sel;
  logic       ld_rt;
  logic       ld_reg;
  logic       ld_flags;
  logic       imm_sel;
  logic [1:0] alu_op;
  logic       retire;
  logic       err;

  modport master (
    input  ir_op, ir_cond, ir_func, flag_z, flag_n, mem_ready,
    output mem_req, mem_we, addr_sel, ld_ir, ld_pc, pc_sel, ld_rt,
           ld_reg, ld_flags, imm_sel, alu_op, retire, err
  );

  modport slave (
    output ir_op, ir_cond, ir_func, flag_z, flag_n, mem_ready,
    input  mem_req, mem_we, addr_sel, ld_ir, ld_pc, pc_sel, ld_rt,
           ld_reg, ld_flags, imm_sel, alu_op, retire, err
  );
endinterface

// File: rtl/control_unit.sv
// Sequencing FSM: fetch, decode, memory access and ALU execute, with
// branch resolution and a sticky trap on illegal ALU codes or memory timeout.
module control_unit #(
  parameter int MEM_WAIT_MAX = 15
) (
  input logic          clk,
  input logic          rst,
  control_unit_if.master cu
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    MEM    = 3'd2,
    EXEC   = 3'd3,
    ERR    = 3'd4
  } state_t;

  localparam int CNT_W = (MEM_WAIT_MAX < 32'sd2) ? 1 : $clog2(MEM_WAIT_MAX + 32'sd1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT_MAX - 32'sd1);
  localparam bit TIMEOUT_EN = (MEM_WAIT_MAX > 32'sd0);

  state_t             state_r;
  state_t             state_next_s;
  logic [CNT_W-1:0]   wait_cnt_r;
  logic               timeout_s;

  logic       mem_req_s, mem_we_s, addr_sel_s, ld_ir_s, ld_pc_s, pc_sel_s;
  logic       ld_rt_s, ld_reg_s, ld_flags_s, imm_sel_s, retire_s, err_s;
  logic [1:0] alu_op_s;

  function automatic logic branch_taken(input logic [2:0] cond, input logic z, input logic n);
    logic taken;
    case (cond)
      3'b000:  taken = 1'b1;
      3'b001:  taken = z;
      3'b010:  taken = n;
      3'b011:  taken = n | z;
      3'b100:  taken = 1'b0;
      3'b101:  taken = ~z;
      3'b110:  taken = ~n;
      3'b111:  taken = ~n & ~z;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  // Trap fires when the wait about to be counted is the MEM_WAIT_MAX-th one.
  assign timeout_s = TIMEOUT_EN && (wait_cnt_r == CNT_LAST) && !cu.mem_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Consecutive wait counter; any move into FETCH or MEM starts it afresh
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r <= '0;
    end else if (((state_r == FETCH) || (state_r == MEM)) && (state_next_s == state_r)) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end else begin
      wait_cnt_r <= '0;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_next_s = state_r;
    mem_req_s    = 1'b0;
    mem_we_s     = 1'b0;
    addr_sel_s   = 1'b0;
    ld_ir_s      = 1'b0;
    ld_pc_s      = 1'b0;
    pc_sel_s     = 1'b0;
    ld_rt_s      = 1'b0;
    ld_reg_s     = 1'b0;
    ld_flags_s   = 1'b0;
    imm_sel_s    = 1'b0;
    alu_op_s     = 2'b00;
    retire_s     = 1'b0;
    err_s        = 1'b0;
    case (state_r)
      FETCH: begin
        mem_req_s = 1'b1;
        if (cu.mem_ready) begin
          ld_ir_s      = 1'b1;
          ld_pc_s      = 1'b1;
          state_next_s = DECODE;
        end else if (timeout_s) begin
          state_next_s = ERR;
        end else begin
          state_next_s = FETCH;
        end
      end
      DECODE: begin
        ld_rt_s = 1'b1;
        case (cu.ir_op)
          2'b10: begin
            if (branch_taken(cu.ir_cond, cu.flag_z, cu.flag_n)) begin
              ld_pc_s  = 1'b1;
              pc_sel_s = 1'b1;
            end else begin
              ld_pc_s  = 1'b0;
            end
            retire_s     = 1'b1;
            state_next_s = FETCH;
          end
          2'b11: begin
            if ((cu.ir_func == 3'b010) || (cu.ir_func == 3'b011)) begin
              state_next_s = ERR;
            end else begin
              state_next_s = EXEC;
            end
          end
          default: state_next_s = MEM;
        endcase
      end
      MEM: begin
        mem_req_s  = 1'b1;
        addr_sel_s = 1'b1;
        mem_we_s   = (cu.ir_op == 2'b01);
        if (cu.mem_ready) begin
          ld_reg_s     = (cu.ir_op == 2'b00);
          ld_flags_s   = (cu.ir_op == 2'b00);
          retire_s     = 1'b1;
          state_next_s = FETCH;
        end else if (timeout_s) begin
          state_next_s = ERR;
        end else begin
          state_next_s = MEM;
        end
      end
      EXEC: begin
        ld_reg_s     = 1'b1;
        ld_flags_s   = 1'b1;
        retire_s     = 1'b1;
        state_next_s = FETCH;
        case (cu.ir_func)
          3'b000:  begin alu_op_s = 2'b00; imm_sel_s = 1'b1; end
          3'b001:  begin alu_op_s = 2'b01; imm_sel_s = 1'b1; end
          3'b100:  begin alu_op_s = 2'b00; imm_sel_s = 1'b0; end
          3'b101:  begin alu_op_s = 2'b01; imm_sel_s = 1'b0; end
          3'b110:  begin alu_op_s = 2'b10; imm_sel_s = 1'b0; end
          3'b111:  begin alu_op_s = 2'b11; imm_sel_s = 1'b0; end
          default: begin alu_op_s = 2'b00; imm_sel_s = 1'b0; end
        endcase
      end
      ERR: begin
        err_s        = 1'b1;
        state_next_s = ERR;
      end
      default: state_next_s = FETCH;
    endcase
  end

  // Gating with rst kills any in-flight strobe (e.g. a write) the instant reset rises.
  assign cu.mem_req  = mem_req_s  & ~rst;
  assign cu.mem_we   = mem_we_s   & ~rst;
  assign cu.addr_sel = addr_sel_s & ~rst;
  assign cu.ld_ir    = ld_ir_s    & ~rst;
  assign cu.ld_pc    = ld_pc_s    & ~rst;
  assign cu.pc_sel   = pc_sel_s   & ~rst;
  assign cu.ld_rt    = ld_rt_s    & ~rst;
  assign cu.ld_reg   = ld_reg_s   & ~rst;
  assign cu.ld_flags = ld_flags_s & ~rst;
  assign cu.imm_sel  = imm_sel_s  & ~rst;
  assign cu.alu_op   = alu_op_s   & {2{~rst}};
  assign cu.retire   = retire_s   & ~rst;
  assign cu.err      = err_s      & ~rst;

endmodule
